ec_pulse_gen: RTL and testbench

Upstream front-end for the 4-bit enable-gated counter. It turns a raw, bouncing, asynchronous push-button level into the counter's EC count-enable pulse.
- Synchronises the button into the clk domain, debounces it, and emits one single-cycle EC pulse per press.
- Optionally auto-repeats EC while the button is held.
- Shares the counter's clk and r.

---
 rtl/ec_pulse_gen.sv | 103 ++++++++++
 tb/tb_ec_pulse_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ec_pulse_gen.sv
// Push-button front-end: synchronise, debounce, and turn presses into single-cycle
// EC count-enable pulses, with optional auto-repeat while the button is held.
module ec_pulse_gen #(
    parameter int DB_CYCLES     = 16,
    parameter int HOLD_CYCLES   = 64,
    parameter int REPEAT_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic r,
    input  logic btn,
    input  logic rpt_en,
    output logic EC,
    output logic btn_db,
    output logic held
);

    typedef enum logic [1:0] {IDLE, PRESS, REPEAT} state_t;

    logic             s1, s2;
    logic [CNT_W-1:0] db_cnt;
    logic             db_nxt;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] tmr, tmr_nxt;
    logic             ec_nxt;
    logic             hold_done, rep_done, db_rise;

    // The FSM looks at the debounced level as it will be after this edge, so a
    // press pulse lands with btn_db and a release beats a same-edge timer expiry.
    always_comb begin
        db_nxt = btn_db;
        if (s2 != btn_db && db_cnt == CNT_W'(DB_CYCLES - 1))
            db_nxt = s2;
    end

    always_ff @(posedge clk) begin
        if (r) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db_cnt <= '0;
            btn_db <= 1'b0;
        end else begin
            s1     <= btn;
            s2     <= s1;
            btn_db <= db_nxt;
            if (s2 == btn_db || db_cnt == CNT_W'(DB_CYCLES - 1))
                db_cnt <= '0;
            else
                db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    assign hold_done = (tmr == CNT_W'(HOLD_CYCLES - 1));
    assign rep_done  = (tmr == CNT_W'(REPEAT_CYCLES - 1));
    assign db_rise   = db_nxt & ~btn_db;

    always_ff @(posedge clk) begin
        if (r) begin
            state <= IDLE;
            tmr   <= '0;
            EC    <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            EC    <= ec_nxt;
            held  <= (state_nxt == REPEAT);
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = '0;
        case (state)
            IDLE: begin
                if (db_rise) state_nxt = PRESS;
            end
            PRESS: begin
                if (!db_nxt)          state_nxt = IDLE;
                else if (!rpt_en)     tmr_nxt   = '0;
                else if (hold_done)   state_nxt = REPEAT;
                else                  tmr_nxt   = tmr + CNT_W'(1);
            end
            REPEAT: begin
                if (!db_nxt)          state_nxt = IDLE;
                else if (!rpt_en)     state_nxt = PRESS;
                else if (!rep_done)   tmr_nxt   = tmr + CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ec_nxt = 1'b0;
        case (state)
            IDLE:    ec_nxt = db_rise;
            PRESS:   ec_nxt = db_nxt & rpt_en & hold_done;
            REPEAT:  ec_nxt = db_nxt & rpt_en & rep_done;
            default: ec_nxt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ec_pulse_gen.sv
// Directed bench for ec_pulse_gen with DB=4, HOLD=8, REPEAT=3; edge numbers in
// each scenario count from the first edge after the stimulus change.
module tb_ec_pulse_gen;

    logic clk = 1'b0;
    logic r, btn, rpt_en;
    logic EC, btn_db, held;
    int   checks   = 0;
    int   failures = 0;
    int   e        = 0;

    ec_pulse_gen #(
        .DB_CYCLES    (4),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(3),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .r     (r),
        .btn   (btn),
        .rpt_en(rpt_en),
        .EC    (EC),
        .btn_db(btn_db),
        .held  (held)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%0b expected=%0b", tag, e, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic x_ec, input logic x_db, input logic x_held);
        chk({tag, ".EC"},     EC,     x_ec);
        chk({tag, ".btn_db"}, btn_db, x_db);
        chk({tag, ".held"},   held,   x_held);
    endtask

    initial begin
        // 1: reset with button held high, then press seen after release of r
        r = 1'b1; btn = 1'b1; rpt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk3("reset", 1'b0, 1'b0, 1'b0);
        end
        r = 1'b0; e = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk3("post_reset", e == 6, e >= 6, 1'b0);
        end

        // 2: release, clean press without repeat, release again
        btn = 1'b0; e = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk3("release1", 1'b0, e < 6, 1'b0);
        end
        btn = 1'b1; e = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            chk3("clean_press", e == 6, e >= 6, 1'b0);
        end
        btn = 1'b0; e = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk3("release2", 1'b0, e < 6, 1'b0);
        end

        // 3: bounce, two cycles per level, then stable high
        e = 0;
        for (int i = 0; i < 12; i++) begin
            btn = ((i / 2) % 2 == 0);
            step();
            chk3("bounce", 1'b0, 1'b0, 1'b0);
        end
        btn = 1'b1; e = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk3("after_bounce", e == 6, e >= 6, 1'b0);
        end
        btn = 1'b0; e = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk3("release3", 1'b0, e < 6, 1'b0);
        end

        // 4: auto-repeat while held; repeats continue until btn_db falls
        rpt_en = 1'b1; btn = 1'b1; e = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            chk3("repeat", e == 6 || (e >= 14 && (e - 14) % 3 == 0), e >= 6, e >= 14);
        end
        btn = 1'b0; e = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk3("repeat_release", e == 2 || e == 5, e < 6, e < 6);
        end

        // 5: release lands on the edge the repeat timer expires
        btn = 1'b1; e = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            chk3("collision", e == 6 || e == 14 || e == 17 || e == 20,
                 e >= 6 && e < 23, e >= 14 && e < 23);
            if (e == 17) btn = 1'b0;
        end

        // 6: reset pulse in REPEAT with button still held
        btn = 1'b1; e = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk3("pre_mid_reset", e == 6 || e == 14, e >= 6, e >= 14);
        end
        r = 1'b1;
        step();
        chk3("mid_reset", 1'b0, 1'b0, 1'b0);
        r = 1'b0; e = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk3("after_mid_reset", e == 6 || e == 14, e >= 6, e >= 14);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
